// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Constants shared by the VGA display pipeline. These are the
//                pixel colour width, the blanking colour and the priority
//                index of each display layer (0 = drawn on top).
//  Revision    : 1.0  initial release
// ============================================================================
package vga_pkg;

   localparam int COLOR_W = 12;

   localparam logic [COLOR_W-1:0] RGB_BLACK = 12'h000;

   // Layer priority slots; a lower index is drawn above a higher one.
   localparam int LAYER_RING  = 0;
   localparam int LAYER_HOUR  = 1;
   localparam int LAYER_DATE  = 2;
   localparam int LAYER_TIMER = 3;
   localparam int LAYER_TEXT  = 4;
   localparam int LAYER_SIMB  = 5;
   localparam int LAYER_IMG   = 6;
   localparam int LAYER_ANIM  = 7;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_blink_timer.sv
`default_nettype none
// ============================================================================
//  Module      : vga_blink_timer
//  Description : Counts frame_start pulses and toggles the blink phase once
//                every BLINK_FRAMES frames.
//  Ports       : clk           system clock
//                reset         synchronous active-high reset
//                i_frame_start 1-clk pulse at the first pixel of a frame
//                o_blink_phase current blink phase (1 = blinking layers hidden)
//  Revision    : 1.0  initial release
// ============================================================================
module vga_blink_timer #(
   parameter int BLINK_FRAMES = 30
) (
   input  logic clk,
   input  logic reset,
   input  logic i_frame_start,
   output logic o_blink_phase
);

   // A width of at least one bit keeps BLINK_FRAMES = 1 legal; the counter
   // then sits at 0 and the phase toggles on every frame.
   localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_phase;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt   <= '0;
         r_phase <= 1'b0;
      end else if (i_frame_start) begin
         if (r_cnt == C_CNT_LAST) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_blink_phase = r_phase;

endmodule : vga_blink_timer
`default_nettype wire

// File: rtl/vga_layer_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : vga_layer_mixer
//  Description : Fixed-priority merge of NUM_LAYERS pixel layers over a
//                background colour. It has per-layer enable and blink masks,
//                and both masks change only on frame boundaries. The datapath
//                is a 2-stage pipeline that advances on pixel_tick.
//  Ports       : clk, reset            clock, synchronous active-high reset
//                pixel_tick            pipeline advance enable
//                video_on              visible-area flag aligned with layers
//                frame_start           1-clk pulse at first pixel of a frame
//                layer_rgb/layer_valid per-layer colour and opacity
//                layer_en_in           requested enables (next frame)
//                blink_mask_in         requested blink mask (next frame)
//                bg_rgb                background colour
//                rgb, video_on_out     pixel to DAC and its aligned flag
//                active_layer          winning layer (NUM_LAYERS = background)
//                blink_phase           current blink phase
//  Revision    : 1.0  initial release
// ============================================================================
module vga_layer_mixer #(
   parameter  int NUM_LAYERS   = 8,
   parameter  int COLOR_W      = 12,
   parameter  int BLINK_FRAMES = 30,
   localparam int SEL_W        = $clog2(NUM_LAYERS + 1)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          pixel_tick,
   input  logic                          video_on,
   input  logic                          frame_start,
   input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
   input  logic [NUM_LAYERS-1:0]         layer_valid,
   input  logic [NUM_LAYERS-1:0]         layer_en_in,
   input  logic [NUM_LAYERS-1:0]         blink_mask_in,
   input  logic [COLOR_W-1:0]            bg_rgb,
   output logic [COLOR_W-1:0]            rgb,
   output logic                          video_on_out,
   output logic [SEL_W-1:0]              active_layer,
   output logic                          blink_phase
);

   import vga_pkg::*;

   localparam logic [COLOR_W-1:0] C_BLANK = COLOR_W'(RGB_BLACK);
   localparam logic [SEL_W-1:0]   C_BG_SEL = SEL_W'(NUM_LAYERS);

   // Lowest set index wins. The loop walks downward so that the last
   // assignment comes from the lowest index.
   function automatic logic [SEL_W-1:0] f_first_set(
      input logic [NUM_LAYERS-1:0] vec
   );
      logic [SEL_W-1:0] sel;
      sel = C_BG_SEL;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (vec[i]) sel = SEL_W'(i);
      end
      return sel;
   endfunction

   // Shadow masks: loaded only on frame_start so a frame is never torn.
   logic [NUM_LAYERS-1:0]         r_en_sh;
   logic [NUM_LAYERS-1:0]         r_mask_sh;
   logic                          w_blink_phase;

   // Stage 1
   logic [NUM_LAYERS*COLOR_W-1:0] r_s1_rgb;
   logic [NUM_LAYERS-1:0]         r_s1_eff;
   logic                          r_s1_vid;
   logic [COLOR_W-1:0]            r_s1_bg;

   // Stage 2
   logic [COLOR_W-1:0]            r_rgb;
   logic                          r_vid;
   logic [SEL_W-1:0]              r_sel;

   logic [NUM_LAYERS-1:0]         w_eff;
   logic [SEL_W-1:0]              w_sel;
   logic [COLOR_W-1:0]            w_win_rgb;

   vga_blink_timer #(
      .BLINK_FRAMES (BLINK_FRAMES)
   ) u_blink (
      .clk           (clk),
      .reset         (reset),
      .i_frame_start (frame_start),
      .o_blink_phase (w_blink_phase)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_en_sh   <= '0;
         r_mask_sh <= '0;
      end else if (frame_start) begin
         r_en_sh   <= layer_en_in;
         r_mask_sh <= blink_mask_in;
      end
   end

   // Uses the current (pre-update) shadow and phase values, so a frame_start
   // that coincides with a pixel_tick takes effect from the next tick.
   assign w_eff = layer_valid & r_en_sh & ~(r_mask_sh & {NUM_LAYERS{w_blink_phase}});

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_rgb <= '0;
         r_s1_eff <= '0;
         r_s1_vid <= 1'b0;
         r_s1_bg  <= '0;
      end else if (pixel_tick) begin
         r_s1_rgb <= layer_rgb;
         r_s1_eff <= w_eff;
         r_s1_vid <= video_on;
         r_s1_bg  <= bg_rgb;
      end
   end

   assign w_sel = f_first_set(r_s1_eff);

   // Colour mux built as a loop rather than by slicing with w_sel. This
   // avoids an out-of-range part-select when the background wins.
   always_comb begin
      w_win_rgb = r_s1_bg;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (r_s1_eff[i]) w_win_rgb = r_s1_rgb[i*COLOR_W +: COLOR_W];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rgb <= C_BLANK;
         r_vid <= 1'b0;
         r_sel <= C_BG_SEL;
      end else if (pixel_tick) begin
         r_rgb <= r_s1_vid ? w_win_rgb : C_BLANK;
         r_vid <= r_s1_vid;
         r_sel <= w_sel;
      end
   end

   assign rgb          = r_rgb;
   assign video_on_out = r_vid;
   assign active_layer = r_sel;
   assign blink_phase  = w_blink_phase;

endmodule : vga_layer_mixer
`default_nettype wire

// File: tb/tb_vga_layer_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_layer_mixer
//  Description : Self-checking bench for vga_layer_mixer against a behavioural
//                reference model, directed scenarios followed by random ones.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_layer_mixer;

   localparam int NL = 8;
   localparam int CW = 12;
   localparam int BF = 2;

   logic           clk = 1'b0;
   logic           reset;
   logic           pixel_tick;
   logic           video_on;
   logic           frame_start;
   logic [NL*CW-1:0] layer_rgb;
   logic [NL-1:0]  layer_valid;
   logic [NL-1:0]  layer_en_in;
   logic [NL-1:0]  blink_mask_in;
   logic [CW-1:0]  bg_rgb;
   logic [CW-1:0]  rgb;
   logic           video_on_out;
   logic [3:0]     active_layer;
   logic           blink_phase;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   vga_layer_mixer #(
      .NUM_LAYERS   (NL),
      .COLOR_W      (CW),
      .BLINK_FRAMES (BF)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .pixel_tick    (pixel_tick),
      .video_on      (video_on),
      .frame_start   (frame_start),
      .layer_rgb     (layer_rgb),
      .layer_valid   (layer_valid),
      .layer_en_in   (layer_en_in),
      .blink_mask_in (blink_mask_in),
      .bg_rgb        (bg_rgb),
      .rgb           (rgb),
      .video_on_out  (video_on_out),
      .active_layer  (active_layer),
      .blink_phase   (blink_phase)
   );

   // ---------------- reference model ----------------
   logic [NL-1:0]    m_en, m_mask;
   int               m_frames;
   logic [CW-1:0]    m_lay [NL];
   logic [NL-1:0]    m_opaque;
   logic             m_vis;
   logic [CW-1:0]    m_bg;
   logic [CW-1:0]    m_rgb;
   logic             m_vo;
   int               m_act;

   // Phase is 1 during odd-numbered blocks of BF frames.
   function automatic logic ph_of(input int frames);
      return ((frames / BF) % 2) == 1;
   endfunction

   task automatic model_step();
      logic ph;
      int   win;
      ph = ph_of(m_frames);
      if (reset) begin
         m_en = '0; m_mask = '0; m_frames = 0;
         for (int i = 0; i < NL; i++) m_lay[i] = '0;
         m_opaque = '0; m_vis = 1'b0; m_bg = '0;
         m_rgb = '0; m_vo = 1'b0; m_act = NL;
      end else begin
         if (pixel_tick) begin
            win = NL;
            for (int i = 0; i < NL; i++) begin
               if (m_opaque[i] && win == NL) win = i;
            end
            m_act = win;
            m_vo  = m_vis;
            if (!m_vis)        m_rgb = '0;
            else if (win < NL) m_rgb = m_lay[win];
            else               m_rgb = m_bg;
            for (int i = 0; i < NL; i++) begin
               m_lay[i]    = layer_rgb[i*CW +: CW];
               m_opaque[i] = layer_valid[i] && m_en[i] && !(m_mask[i] && ph);
            end
            m_vis = video_on;
            m_bg  = bg_rgb;
         end
         if (frame_start) begin
            m_en = layer_en_in;
            m_mask = blink_mask_in;
            m_frames++;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v)
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
      else
         n_pass++;
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      chk("rgb",   32'(rgb),          32'(m_rgb));
      chk("vid",   32'(video_on_out), 32'(m_vo));
      chk("act",   32'(active_layer), 32'(m_act));
      chk("phase", 32'(blink_phase),  32'(ph_of(m_frames)));
   endtask

   task automatic set_layer(input int idx, input logic [CW-1:0] val);
      layer_rgb[idx*CW +: CW] = val;
   endtask

   initial begin
      reset = 1'b1; pixel_tick = 1'b0; video_on = 1'b0; frame_start = 1'b0;
      layer_rgb = '0; layer_valid = '0; layer_en_in = '0; blink_mask_in = '0;
      bg_rgb = '0;
      m_frames = 0;
      #2;
      cyc(); cyc();
      chk("rst_rgb", 32'(rgb), 32'h0);
      chk("rst_act", 32'(active_layer), 32'd8);

      // 1: layers valid but no frame_start yet -> background only
      reset = 1'b0; video_on = 1'b1; layer_valid = 8'hFF; layer_en_in = 8'hFF;
      for (int i = 0; i < NL; i++) set_layer(i, CW'($urandom));
      bg_rgb = 12'h123; pixel_tick = 1'b1;
      repeat (3) cyc();
      chk("t1_bg",  32'(rgb), 32'h123);
      chk("t1_act", 32'(active_layer), 32'd8);

      // 2: enable everything, layer 2 beats layer 5 after two ticks
      pixel_tick = 1'b0; frame_start = 1'b1; cyc();
      frame_start = 1'b0; layer_valid = 8'b0010_0100;
      set_layer(2, 12'hF00); set_layer(5, 12'h0F0);
      pixel_tick = 1'b1; cyc();
      chk("t2_lat1", 32'(rgb), 32'h123);
      cyc();
      chk("t2_rgb", 32'(rgb), 32'hF00);
      chk("t2_act", 32'(active_layer), 32'd2);

      // 3: blink layer 2 over several frames
      blink_mask_in = 8'h04;
      for (int f = 0; f < 6; f++) begin
         frame_start = 1'b1; cyc();
         frame_start = 1'b0; repeat (3) cyc();
         chk("t3_blink", 32'(rgb), blink_phase ? 32'h0F0 : 32'hF00);
      end

      // 4: mid-frame enable change has no effect until frame_start
      blink_mask_in = 8'h00; frame_start = 1'b1; cyc(); frame_start = 1'b0;
      repeat (2) cyc();
      layer_en_in = 8'h20;
      repeat (3) cyc();
      chk("t4_hold", 32'(rgb), 32'hF00);
      frame_start = 1'b1; cyc(); frame_start = 1'b0;
      cyc();
      chk("t4_old", 32'(rgb), 32'hF00);
      cyc();
      chk("t4_new", 32'(rgb), 32'h0F0);

      // 5: blanking, then frozen pipeline
      video_on = 1'b0; repeat (2) cyc();
      chk("t5_blank", 32'(rgb), 32'h0);
      chk("t5_vo", 32'(video_on_out), 32'h0);
      video_on = 1'b1; pixel_tick = 1'b0; set_layer(5, 12'h00F);
      repeat (4) cyc();
      chk("t5_frozen", 32'(rgb), 32'h0);

      // 6: reset mid-line
      pixel_tick = 1'b1; repeat (3) cyc();
      reset = 1'b1; cyc();
      chk("t6_rgb", 32'(rgb), 32'h0);
      chk("t6_act", 32'(active_layer), 32'd8);
      reset = 1'b0; repeat (3) cyc();
      chk("t6_bg", 32'(rgb), 32'(bg_rgb));

      // random traffic
      for (int n = 0; n < 1500; n++) begin
         reset         = ($urandom_range(0, 599) == 0);
         pixel_tick    = ($urandom_range(0, 3) != 0);
         video_on      = ($urandom_range(0, 7) != 0);
         frame_start   = ($urandom_range(0, 29) == 0);
         layer_valid   = NL'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            layer_en_in   = NL'($urandom);
            blink_mask_in = NL'($urandom);
         end
         bg_rgb = CW'($urandom);
         for (int i = 0; i < NL; i++) set_layer(i, CW'($urandom));
         cyc();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_vga_layer_mixer
`default_nettype wire
